// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The divide-by-zero quotient helper supports widths up to DIV_MAX_WIDTH.
// Optional feature macro: SEQ_DIV_SIGNED_EN (two's-complement division).
package seq_div_pkg;

  // Controller states; IDLE is the reset state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;
  localparam int DIV_MAX_WIDTH     = 128;

  // All-ones pattern of w bits, right-aligned; used as the divide-by-zero quotient.
  function automatic logic [DIV_MAX_WIDTH-1:0] dbz_quotient(input int w);
    return {DIV_MAX_WIDTH{1'b1}} >> (DIV_MAX_WIDTH - w);
  endfunction

endpackage

// File: rtl/seq_restoring_div_step.sv
// One shift/subtract/restore iteration of the restoring divider.
// Purely combinational; the top registers its outputs once per RUN cycle.
module restoring_div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sh_r;
  logic [WIDTH:0] diff;
  // The partial remainder is always below the divisor, so its top bit is
  // zero on entry and is dropped by the shift.
  logic           unused_r_msb;

  assign unused_r_msb = r_i[WIDTH];

  // Shift {R,Q} left, trial-subtract M, keep or restore the remainder.
  always_comb begin
    sh_r = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
    diff = sh_r - {1'b0, m_i};
    r_o  = sh_r;
    q_o  = {q_i[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      r_o    = diff;
      q_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done
// handshake. Optional signed division is compiled in with SEQ_DIV_SIGNED_EN.
// Handshake: start is sampled only in IDLE; busy is high while RUN/FIX are
// active; done is a one-cycle pulse in DONE, and quotient/remainder/
// div_by_zero are valid from that cycle and held until the next accept.
// state_dbg exposes the controller state for observation.
module seq_restoring_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_QUO = WIDTH'(dbz_quotient(WIDTH));

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] fix_quo, fix_rem;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .m_i (m_q),
    .r_o (r_step),
    .q_o (q_step)
  );

`ifdef SEQ_DIV_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  // Iterate on magnitudes; remember which signs must be restored in FIX.
  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;
  assign fix_quo = neg_quo_q ? -q_q : q_q;
  assign fix_rem = neg_rem_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
`else
  logic unused_signed_op;

  // Unsigned-only build: operands pass straight through, FIX is a pass stage.
  assign unused_signed_op = signed_op;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign fix_quo = q_q;
  assign fix_rem = r_q[WIDTH-1:0];
`endif

  // Next-state and datapath update for the IDLE/RUN/FIX/DONE controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    m_d     = m_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide by zero skips the iteration and reports at once.
            quo_d   = DBZ_QUO;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = '0;
            q_d     = dvd_mag;
            m_d     = dvs_mag;
            cnt_d   = CW'(WIDTH - 1);
            state_d = RUN;
`ifdef SEQ_DIV_SIGNED_EN
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
`endif
          end
        end
      end
      RUN: begin
        r_d = r_step;
        q_d = q_step;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        // Results become visible together with the done pulse.
        quo_d   = fix_quo;
        rem_d   = fix_rem;
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy      = (state_q == RUN) || (state_q == FIX);
    done      = (state_q == DONE);
    state_dbg = state_q;
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      m_q     <= m_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Bench for seq_restoring_div (WIDTH = 32): directed divisions checked against
// a plain-arithmetic model every cycle, plus literal expectations per vector.
// Signed expectations apply when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_restoring_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  seq_restoring_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_z[$];
  int           exp_cyc[$];
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;
  logic         held_z = 1'b0;
  int           busy_lo = 1;
  int           busy_hi = 0;
  int           last_done_cyc = -1;
  bit           chk_en = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from plain arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    logic sg;
`ifdef SEQ_DIV_SIGNED_EN
    sg = s;
`else
    sg = s & 1'b0;
`endif
    z = 1'b0;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic         exp_done;
    logic [W-1:0] eq, er;
    logic         ez;
    if (chk_en) begin
      exp_done = (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
      check("busy", W'(busy), W'((cyc >= busy_lo) && (cyc <= busy_hi)));
      check("done", W'(done), W'(exp_done));
      eq = held_q;
      er = held_r;
      ez = held_z;
      if (exp_done) begin
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        ez = exp_z.pop_front();
        void'(exp_cyc.pop_front());
        last_done_cyc <= cyc;
      end
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("div_by_zero", W'(div_by_zero), W'(ez));
      held_q <= eq;
      held_r <= er;
      held_z <= ez;
    end
  end

  // ---------------- driver tasks (called at #1 after a rising edge) ----------------
  task automatic wait_idle();
    int k = 0;
    while ((busy || done) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_int("idle_timeout", k < 200 ? 1 : 0, 1);
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int t);
    logic [W-1:0] q, r;
    logic         z;
    wait_idle();
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    t         = cyc;
    model(a, b, s, q, r, z);
    exp_q.push_back(q);
    exp_r.push_back(r);
    exp_z.push_back(z);
    if (b == '0) begin
      exp_cyc.push_back(t + 1);
      busy_lo = 1;
      busy_hi = 0;
    end else begin
      exp_cyc.push_back(t + W + 2);
      busy_lo = t + 1;
      busy_hi = t + W + 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_result(input int t, input int lat);
    int k = 0;
    while (exp_cyc.size() > 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check_int("result_timeout", k < 100 ? 1 : 0, 1);
    check_int("latency", last_done_cyc - t, lat);
  endtask

  // Clear the model the same way the reset edge clears the DUT.
  task automatic flush_model();
    exp_q.delete();
    exp_r.delete();
    exp_z.delete();
    exp_cyc.delete();
    held_q  = '0;
    held_r  = '0;
    held_z  = 1'b0;
    busy_lo = 1;
    busy_hi = 0;
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] lq, input logic [W-1:0] lr, input logic lz,
                         input string tag);
    int t;
    do_div(a, b, s, t);
    wait_result(t, (b == '0) ? 1 : W + 2);
    check({tag, "_q"}, quotient, lq);
    check({tag, "_r"}, remainder, lr);
    check({tag, "_z"}, W'(div_by_zero), W'(lz));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    clr_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    clr_n  = 1'b1;
    chk_en = 1'b1;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", W'(div_by_zero), '0);

    run_vec(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "u100_7");
    run_vec(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, "dbz");
`ifdef SEQ_DIV_SIGNED_EN
    run_vec(-32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s_m7_2");
    run_vec(32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, "s_7_m2");
    run_vec(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, "s_ovf");
`else
    run_vec(-32'sd7, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, "s_m7_2");
    run_vec(32'd7, -32'sd2, 1'b1, 32'd0, 32'd7, 1'b0, "s_7_m2");
    run_vec(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, "s_ovf");
`endif
    run_vec(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, "max_1");
    run_vec(32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0, "small");
    run_vec(32'd0, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, "zero_dvd");

    // start pulse at T+5 while busy must be ignored (a zero divisor would show).
    do_div(32'd200, 32'd9, 1'b0, t);
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd55;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_result(t, W + 2);
    check("busy_start_q", quotient, 32'd22);
    check("busy_start_r", remainder, 32'd2);
    repeat (5) @(posedge clk);
    #1;

    // Reset at T+10 mid-run: no done, outputs cleared.
    do_div(32'hDEAD_BEEF, 32'd3, 1'b0, t);
    repeat (9) @(posedge clk);
    #1;
    check_int("rst_mid_cycle", cyc - t, 10);
    clr_n = 1'b0;
    @(posedge clk);
    flush_model();
    #1;
    clr_n = 1'b1;
    check("mid_rst_busy", W'(busy), '0);
    check("mid_rst_quotient", quotient, '0);
    check("mid_rst_remainder", remainder, '0);
    check("mid_rst_dbz", W'(div_by_zero), '0);
    repeat (40) @(posedge clk);
    #1;
    run_vec(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, "after_rst");

    // Reset and start in the same cycle: reset wins, nothing starts.
    dividend = 32'd9;
    divisor  = 32'd0;
    start    = 1'b1;
    clr_n    = 1'b0;
    @(posedge clk);
    flush_model();
    #1;
    start = 1'b0;
    clr_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_start_q", quotient, '0);
    run_vec(32'd1000, 32'd1000, 1'b0, 32'd1, 32'd0, 1'b0, "eq_ops");

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_restoring_div.md
# seq_restoring_div

Multi-cycle, parametrised restoring divider for the CPU datapath. It produces one quotient bit per clock using a shift/subtract/restore iteration and uses a start/done handshake toward the control unit. It serves DIV instructions and replaces any single-cycle divide path. The block adds divide-by-zero detection and, optionally, signed division.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  clock; all state changes on rising edge
- clr_n  in  1  reset, synchronous, active-low
- start  in  1  begin division; sampled only in IDLE
- signed_op  in  1  1 = two's-complement divide (honoured only with SEQ_DIV_SIGNED_EN)
- dividend  in  WIDTH  dividend, captured when start is accepted
- divisor  in  WIDTH  divisor, captured when start is accepted
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  WIDTH  quotient, held until next accept
- remainder  out  WIDTH  remainder, held until next accept
- div_by_zero  out  1  divisor was 0; held with results

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE → RUN on start. Operands are latched and the iteration counter is set to WIDTH-1.
- IDLE → DONE if start is high and divisor == 0.
- RUN → FIX when the counter reaches 0.
- FIX → DONE unconditionally.
- DONE → IDLE unconditionally.
- RUN iteration, once per cycle:
  - Shift {R,Q} left by 1, with the MSB of Q entering R[0].
  - T = R − M, computed WIDTH+1 bits wide.
  - If T[WIDTH] = 1, R is kept (restore) and Q[0] = 0. Otherwise R = T and Q[0] = 1.
- R is WIDTH+1 bits wide internally. Only R[WIDTH-1:0] is output.
- Unsigned results: quotient = dividend / divisor, remainder = dividend mod divisor.
- Signed mode:
  - The iteration runs on operand magnitudes.
  - FIX negates the quotient when the operand signs differ.
  - FIX negates the remainder when the dividend is negative.
  - The remainder sign always follows the dividend.
- Signed overflow (most-negative / −1): quotient = most-negative value (wraps), remainder = 0, no flag.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
- start while busy, or while in DONE, is ignored. No queueing.
- Outputs (quotient, remainder, div_by_zero) update only in the DONE cycle and are stable otherwise.

## Timing
- Reset: state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0.
- Accept at cycle T, normal case:
  - busy is high in cycles T+1 … T+WIDTH+1.
  - done pulses at T+WIDTH+2 (T+34 for WIDTH = 32).
- Accept at cycle T, divide by zero: busy stays 0 and done pulses at T+1.
- The earliest next accept is the cycle after done.
- Reset mid-operation: clr_n low on any edge returns the block to IDLE and clears all outputs. An operation in flight is discarded and no done is issued.
- clr_n and start both active in the same cycle: reset wins.

## Configuration
- SEQ_DIV_SIGNED_EN defined:
  - signed_op is honoured.
  - Magnitude conversion on accept and sign fixup in FIX are compiled in.
- SEQ_DIV_SIGNED_EN undefined:
  - signed_op is ignored and all divisions are unsigned.
  - FIX is still one cycle and passes results through, so latency is identical in both builds.

## Structure
- Package seq_div_pkg holds:
  - the state enum (IDLE, RUN, FIX, DONE);
  - DIV_WIDTH_DEFAULT = 32;
  - a function for the divide-by-zero quotient pattern (all ones of the given width).
- One sub-module: restoring_div_step. It is purely combinational and performs one shift/subtract/restore iteration.
  - Inputs: R, Q, M.
  - Outputs: next R, next Q.
  - It is instantiated once and feeds registers in the top.

## Test plan
- Unsigned 100 / 7, WIDTH = 32 → quotient 14, remainder 2, done exactly 34 cycles after accept.
- divisor = 0, dividend = 0x1234 → done at T+1, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero = 1.
- Signed (macro on) −7 / 2 → quotient −3 (0xFFFFFFFD), remainder −1. Then 7 / −2 → quotient −3, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, div_by_zero = 0.
- start pulsed at T+5 during a busy operation → ignored; the first result and its timing are unchanged, and there is exactly one done.
- clr_n low at T+10 mid-run → IDLE, all outputs 0, no done. A fresh 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF.
